// File: rtl/ram_playback_sequencer.sv
// rtl/ram_playback_sequencer.sv - dwell-timed RAM playback engine with an independent write port
module ram_playback_sequencer #(
  parameter int DATA_W      = 4,
  parameter int ADDR_W      = 5,
  parameter int TICK_CYCLES = 50_000_000
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              write,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [DATA_W-1:0] data,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic              loop,
  input  logic              dir,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  output logic [ADDR_W-1:0] read_addr,
  output logic [DATA_W-1:0] out,
  output logic              out_valid,
  output logic              busy,
  output logic              done
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSED, S_DONE} state_t;

  state_t            state_q, state_d;
  logic              loop_q, loop_d;
  logic              dir_q, dir_d;
  logic [ADDR_W-1:0] first_q, first_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] out_q;
  logic              valid_q, valid_d;
  logic              done_q, done_d;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              active;
  logic              run_tick;
  logic              expire;
  logic [ADDR_W-1:0] win_start;
  logic [ADDR_W-1:0] win_end;

  // The read port samples before the write lands, giving read-before-write on collisions.
  always_ff @(posedge CLOCK_50) begin
    if (write) begin
      mem[write_addr] <= data;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      out_q <= '0;
    end else begin
      out_q <= mem[addr_q];
    end
  end

  assign active    = (state_q == S_RUN) || (state_q == S_PAUSED);
  assign run_tick  = active && !pause;
  assign expire    = run_tick && (cnt_q == CNT_MAX);
  assign win_start = dir_q ? last_q : first_q;
  assign win_end   = dir_q ? first_q : last_q;

  always_comb begin
    state_d = state_q;
    loop_d  = loop_q;
    dir_d   = dir_q;
    first_d = first_q;
    last_d  = last_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;

    if (stop) begin
      state_d = S_IDLE;
    end else if (start) begin
      loop_d  = loop;
      dir_d   = dir;
      first_d = first_addr;
      last_d  = last_addr;
      addr_d  = dir ? last_addr : first_addr;
      cnt_d   = '0;
      state_d = S_RUN;
    end else if (active) begin
      state_d = pause ? S_PAUSED : S_RUN;
      if (expire) begin
        cnt_d = '0;
        if (addr_q == win_end) begin
          if (loop_q) begin
            addr_d = win_start;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end else begin
          addr_d = dir_q ? (addr_q - 1'b1) : (addr_q + 1'b1);
        end
      end else if (run_tick) begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    // Valid only once the RAM has had a cycle to read the first playback address.
    valid_d = active && ((state_d == S_RUN) || (state_d == S_PAUSED));
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      loop_q  <= 1'b0;
      dir_q   <= 1'b0;
      first_q <= '0;
      last_q  <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      loop_q  <= loop_d;
      dir_q   <= dir_d;
      first_q <= first_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign read_addr = addr_q;
  assign out       = out_q;
  assign out_valid = valid_q;
  assign busy      = active;
  assign done      = done_q;

endmodule

// File: tb/tb_ram_playback_sequencer.sv
// tb/tb_ram_playback_sequencer.sv - randomized model-checked bench for ram_playback_sequencer
module tb_ram_playback_sequencer;
  localparam int DW    = 4;
  localparam int AW    = 3;
  localparam int TK    = 4;
  localparam int DEPTH = 1 << AW;
  localparam int MASK  = DEPTH - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr = 1'b0;
  logic [AW-1:0] waddr = '0;
  logic [DW-1:0] wdata = '0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          pause = 1'b0;
  logic          loop_i = 1'b0;
  logic          dir_i = 1'b0;
  logic [AW-1:0] first = '0;
  logic [AW-1:0] last = '0;
  logic [AW-1:0] read_addr;
  logic [DW-1:0] out_w;
  logic          out_valid;
  logic          busy;
  logic          done;

  ram_playback_sequencer #(.DATA_W(DW), .ADDR_W(AW), .TICK_CYCLES(TK)) dut (
    .CLOCK_50  (clk),
    .reset     (rst_n),
    .write     (wr),
    .write_addr(waddr),
    .data      (wdata),
    .start     (start),
    .stop      (stop),
    .pause     (pause),
    .loop      (loop_i),
    .dir       (dir_i),
    .first_addr(first),
    .last_addr (last),
    .read_addr (read_addr),
    .out       (out_w),
    .out_valid (out_valid),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  // Playback modelled as a precomputed list of window addresses walked by index.
  int mem_m [DEPTH];
  int m_list[DEPTH];
  int m_addr, m_out, m_elapsed, m_idx, m_n;
  bit m_active, m_valid, m_done, m_loop;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 0; m_valid = 0; m_done = 0;
      m_addr = 0; m_out = 0; m_elapsed = 0; m_idx = 0;
    end else begin
      int nxt_out;
      bit was;
      nxt_out = mem_m[m_addr];
      was     = m_active;
      m_done  = 0;
      if (stop) begin
        m_active = 0;
      end else if (start) begin
        m_n = ((int'(last) - int'(first)) & MASK) + 1;
        for (int i = 0; i < DEPTH; i++)
          m_list[i] = dir_i ? ((int'(last) - i) & MASK) : ((int'(first) + i) & MASK);
        m_loop = loop_i; m_idx = 0; m_elapsed = 0; m_active = 1;
        m_addr = m_list[0];
      end else if (m_active && !pause) begin
        m_elapsed++;
        if (m_elapsed == TK) begin
          m_elapsed = 0;
          if (m_idx == m_n - 1) begin
            if (m_loop) begin m_idx = 0; m_addr = m_list[0]; end
            else begin m_active = 0; m_done = 1; end
          end else begin
            m_idx++;
            m_addr = m_list[m_idx];
          end
        end
      end
      m_valid = was && m_active;
      m_out   = nxt_out;
      if (wr) mem_m[waddr] = int'(wdata);
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_busy", busy, m_active);
      chk("m_valid", out_valid, m_valid);
      chk("m_done", done, m_done);
      chk("m_read_addr", read_addr, m_addr);
      if (m_valid) chk("m_out", out_w, m_out);
    end
  end

  task automatic do_start(input int f, input int l, input bit d, input bit lp);
    first = AW'(f); last = AW'(l); dir_i = d; loop_i = lp; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int dcount, bcount, n3, n4, guard, a;
    int seq[$];
    int exp2[8];
    exp2 = '{1, 0, 7, 6, 1, 0, 7, 6};

    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_addr", read_addr, 0);
    chk("rst_out", out_w, 0);
    rst_n = 1'b1;
    cmp_en = 1'b1;

    for (int i = 0; i < DEPTH; i++) begin
      wr = 1'b1; waddr = AW'(i); wdata = DW'(i + 8);
      @(negedge clk);
    end
    wr = 1'b0;

    // Ascending one-shot 2..5
    do_start(2, 5, 0, 0);
    dcount = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k <= 16) chk("asc_out", out_w, 10 + (k - 1) / 4);
      if (k == 16) chk("asc_done_cycle", done, 1);
      if (done) dcount++;
    end
    chk("asc_done_count", dcount, 1);
    chk("asc_busy_end", busy, 0);
    chk("asc_addr_end", read_addr, 5);

    // Descending loop wrapping through zero
    do_start(6, 1, 1, 1);
    seq.delete(); seq.push_back(int'(read_addr));
    dcount = 0; bcount = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!busy) bcount++;
      if (done) dcount++;
      if (int'(read_addr) != seq[$]) seq.push_back(int'(read_addr));
    end
    chk("desc_steps", seq.size() >= 8, 1);
    for (int i = 0; i < 8 && i < seq.size(); i++) chk("desc_seq", seq[i], exp2[i]);
    chk("desc_not_busy", bcount, 0);
    chk("desc_done", dcount, 0);

    // Pause in the middle of address 3's dwell
    do_start(2, 5, 0, 1);
    guard = 0;
    while (read_addr != 3 && guard < 20) begin @(negedge clk); guard++; end
    chk("pause_reach3", read_addr, 3);
    n3 = 1;
    @(negedge clk);
    if (read_addr == 3) n3++;
    pause = 1'b1;
    repeat (10) begin @(negedge clk); if (read_addr == 3) n3++; end
    pause = 1'b0;
    guard = 0;
    while (guard < 30) begin
      @(negedge clk); guard++;
      if (read_addr == 3) n3++; else break;
    end
    chk("pause_hold3", n3, 14);
    chk("pause_next", read_addr, 4);
    n4 = 1; guard = 0;
    while (guard < 30) begin
      @(negedge clk); guard++;
      if (read_addr == 4) n4++; else break;
    end
    chk("pause_hold4", n4, 4);

    // Stop and start together: stop wins
    a = int'(read_addr);
    first = 3'd1; last = 3'd4; dir_i = 1'b0; stop = 1'b1; start = 1'b1;
    @(negedge clk);
    stop = 1'b0; start = 1'b0;
    chk("ss_busy", busy, 0);
    chk("ss_valid", out_valid, 0);
    chk("ss_addr_hold", read_addr, a);
    repeat (3) @(negedge clk);
    chk("ss_idle", busy, 0);
    do_start(1, 4, 0, 1);
    chk("restart_addr", read_addr, 1);
    chk("restart_valid0", out_valid, 0);
    @(negedge clk);
    chk("restart_valid1", out_valid, 1);
    chk("restart_out", out_w, 9);

    // Write collision on the playing address
    guard = 0;
    while (read_addr == 1 && guard < 20) begin @(negedge clk); guard++; end
    a = int'(read_addr);
    chk("coll_addr", a, 2);
    @(negedge clk);
    chk("coll_pre", out_w, 10);
    wr = 1'b1; waddr = AW'(a); wdata = 4'hF;
    @(negedge clk);
    wr = 1'b0;
    chk("coll_old", out_w, 10);
    @(negedge clk);
    chk("coll_new", out_w, 15);
    chk("coll_addr_same", read_addr, a);
    @(negedge clk);
    chk("coll_step", read_addr, a + 1);

    // Asynchronous reset between edges
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_valid", out_valid, 0);
    chk("arst_done", done, 0);
    chk("arst_addr", read_addr, 0);
    chk("arst_out", out_w, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_valid", out_valid, 0);
    chk("post_rst_addr", read_addr, 0);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      start  = ($urandom_range(0, 99) < 5);
      stop   = ($urandom_range(0, 99) < 2);
      if ($urandom_range(0, 99) < 10) pause = ~pause;
      loop_i = 1'($urandom);
      dir_i  = 1'($urandom);
      first  = AW'($urandom);
      last   = AW'($urandom);
      wr     = ($urandom_range(0, 99) < 30);
      waddr  = AW'($urandom);
      wdata  = DW'($urandom);
      @(negedge clk);
    end
    start = 1'b0; stop = 1'b1; wr = 1'b0; pause = 1'b0;
    @(negedge clk);
    stop = 1'b0;
    repeat (3) @(negedge clk);
    cmp_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=0 exp=1");
    $fatal(1);
  end
endmodule
